// File: rtl/wb_slave_pkg.sv
// Shared types and widths for the Wishbone B4 classic slave memory.
package wb_slave_pkg;

  localparam int unsigned WB_DW = 64;
  localparam int unsigned WB_SW = 8;
  localparam int unsigned WB_TW = 16;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    WAIT,
    RESP
  } wb_slv_state_e;

  typedef struct packed {
    logic             we;
    logic [63:0]      adr;
    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
    logic [WB_TW-1:0] tga;
  } wb_req_t;

  // True when the byte address falls inside the DEPTH-word window starting at base.
  function automatic logic word_hit(input logic [63:0] adr, input logic [63:0] base,
                                    input int unsigned depth);
    logic [63:0] off;
    off = adr - base;
    return (adr >= base) && ((off >> 3) < 64'(depth));
  endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone B4 classic bus bundle between a master agent and wb_slave_mem.
interface wb_slave_mem_if;

  logic                             CYC_I;
  logic                             STB_I;
  logic                             WE_I;
  logic [63:0]                      ADR_I;
  logic [wb_slave_pkg::WB_DW-1:0]   DAT_I;
  logic [wb_slave_pkg::WB_SW-1:0]   SEL_I;
  logic [wb_slave_pkg::WB_TW-1:0]   TGA_I;
  logic [wb_slave_pkg::WB_TW-1:0]   TGC_I;
  logic [wb_slave_pkg::WB_TW-1:0]   TGD_I;
  logic                             LOCK_I;
  logic [wb_slave_pkg::WB_DW-1:0]   DAT_O;
  logic [wb_slave_pkg::WB_TW-1:0]   TGD_O;
  logic                             ACK_O;
  logic                             ERR_O;
  logic                             RTY_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, TGA_I, TGC_I, TGD_I, LOCK_I,
    input  DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, TGA_I, TGC_I, TGD_I, LOCK_I,
    output DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
  );

endinterface

// File: rtl/wb_slave_ram.sv
// DEPTH x 64 single-port word RAM with per-byte write enables and a registered read port.
module wb_slave_ram
  import wb_slave_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WB_SW-1:0] be,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WB_DW-1:0] wdata,
  output logic [WB_DW-1:0] rdata
);

  logic [WB_DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < WB_SW; n++) begin
      if (be[n]) begin
        mem[addr][8*n +: 8] <= wdata[8*n +: 8];
      end
    end
  end

  // Read register doubles as the bus data output, so it is zero unless a read is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B4 classic-cycle slave serving a zero-initialised word memory with
// programmable wait states and address-tag echo on every termination.
module wb_slave_mem
  import wb_slave_pkg::*;
#(
  parameter int unsigned  DEPTH       = 256,
  parameter logic [63:0]  BASE_ADDR   = 64'h0,
  parameter int unsigned  WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst,
  wb_slave_mem_if.slave    bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  wb_slv_state_e    state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  wb_req_t          req_q, req_in;
  logic             latch_en;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             rty_q, rty_d;
  logic [WB_TW-1:0] tgd_q, tgd_d;

  logic             req;
  logic             hit;
  logic [AW-1:0]    idx;

  logic [WB_SW-1:0] ram_be;
  logic             ram_re;
  logic [AW-1:0]    ram_addr;
  logic [WB_DW-1:0] ram_wdata;
  logic [WB_DW-1:0] ram_rdata;

  logic             unused_tags;

  assign unused_tags = ^{bus.TGC_I, bus.TGD_I, bus.LOCK_I};

  assign req = bus.CYC_I & bus.STB_I;
  assign hit = word_hit(req_q.adr, BASE_ADDR, DEPTH);
  assign idx = AW'((req_q.adr - BASE_ADDR) >> 3);

  always_comb begin
    req_in     = '0;
    req_in.we  = bus.WE_I;
    req_in.adr = bus.ADR_I;
    req_in.dat = bus.DAT_I;
    req_in.sel = bus.SEL_I;
    req_in.tga = bus.TGA_I;
  end

  // RESP is the RAM access cycle; the registered ACK/ERR and read data appear on the
  // following cycle, while the FSM is already back in IDLE ready to sample the next request.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rty_d     = 1'b0;
    tgd_d     = '0;
    ram_be    = '0;
    ram_re    = 1'b0;
    ram_addr  = idx;
    ram_wdata = req_q.dat;

    unique case (state_q)
      CLEAR: begin
        ram_be    = '1;
        ram_addr  = ptr_q;
        ram_wdata = '0;
        ptr_d     = ptr_q + AW'(1);
        if (ptr_q == LAST) begin
          state_d = IDLE;
        end
        if (req) begin
          rty_d = 1'b1;
          tgd_d = bus.TGA_I;
        end
      end

      IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          cnt_d    = WS;
          state_d  = (WS != 4'd0) ? WAIT : RESP;
        end
      end

      WAIT: begin
        if (!bus.CYC_I) begin
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
        tgd_d   = req_q.tga;
        if (hit) begin
          ack_d = 1'b1;
          if (req_q.we) begin
            ram_be = req_q.sel;
          end else begin
            ram_re = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      tgd_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      tgd_q   <= tgd_d;
      if (latch_en) begin
        req_q <= req_in;
      end
    end
  end

  wb_slave_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .be    (ram_be),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.DAT_O = ram_rdata;
  assign bus.TGD_O = tgd_q;
  assign bus.ACK_O = ack_q;
  assign bus.ERR_O = err_q;
  assign bus.RTY_O = rty_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem: four instances with different base/wait settings.
module tb_wb_slave_mem;

  localparam int unsigned WS_T   [4] = '{2, 1, 4, 0};
  localparam logic [63:0] BASE_T [4] = '{64'h0, 64'h1000, 64'h0, 64'h0};

  logic        clk;
  logic        rst;
  logic [3:0]  cyc, stb, we;
  logic [63:0] adr  [4];
  logic [63:0] wdat [4];
  logic [7:0]  sel  [4];
  logic [15:0] tga  [4];
  wire  [3:0]  ack, err, rty;
  wire  [63:0] dato [4];
  wire  [15:0] tgdo [4];

  int nvec = 0;
  int nerr = 0;

  logic [2:0]  resp;
  logic [63:0] rd;
  logic [15:0] tg;
  int          lat;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    wb_slave_mem_if bus ();
    assign bus.CYC_I  = cyc[g];
    assign bus.STB_I  = stb[g];
    assign bus.WE_I   = we[g];
    assign bus.ADR_I  = adr[g];
    assign bus.DAT_I  = wdat[g];
    assign bus.SEL_I  = sel[g];
    assign bus.TGA_I  = tga[g];
    assign bus.TGC_I  = 16'h0;
    assign bus.TGD_I  = 16'h0;
    assign bus.LOCK_I = 1'b0;
    assign ack[g]     = bus.ACK_O;
    assign err[g]     = bus.ERR_O;
    assign rty[g]     = bus.RTY_O;
    assign dato[g]    = bus.DAT_O;
    assign tgdo[g]    = bus.TGD_O;

    wb_slave_mem #(
      .DEPTH       (256),
      .BASE_ADDR   (BASE_T[g]),
      .WAIT_STATES (WS_T[g])
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One single-beat access; resp = {ACK,ERR,RTY}, lat = edges after the sampling edge.
  task automatic bus_access(input int d, input logic w, input logic [63:0] a,
                            input logic [63:0] dat, input logic [7:0] s, input logic [15:0] tag,
                            output logic [2:0] r, output logic [63:0] rdat,
                            output logic [15:0] rtag, output int l);
    @(negedge clk);
    we[d] = w; adr[d] = a; wdat[d] = dat; sel[d] = s; tga[d] = tag;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    r = '0; rdat = '0; rtag = '0; l = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack[d] | err[d] | rty[d]) begin
        r = {ack[d], err[d], rty[d]}; rdat = dato[d]; rtag = tgdo[d]; l = k - 1;
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 4; d++) begin
      nvec++;
      if ({ack[d], err[d], rty[d]} !== 3'b000 || dato[d] !== 64'h0 || tgdo[d] !== 16'h0) begin
        nerr++;
        $display("FAIL reset_out[%0d]: got ack/err/rty=%b dat=%h tgd=%h, expected all zero",
                 d, {ack[d], err[d], rty[d]}, dato[d], tgdo[d]);
      end
    end
  endtask

  task automatic test_clear_retry();
    repeat (8) @(negedge clk);
    bus_access(0, 1'b0, 64'h20, 64'h0, 8'hFF, 16'h0C0C, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b001) begin nerr++; $display("FAIL clear_rty_resp: got %b expected %b", resp, 3'b001); end
    nvec++; if (lat !== 0) begin nerr++; $display("FAIL clear_rty_lat: got %0d expected %0d", lat, 0); end
    nvec++; if (tg !== 16'h0C0C) begin nerr++; $display("FAIL clear_rty_tag: got %h expected %h", tg, 16'h0C0C); end
    @(negedge clk);
    nvec++; if (rty[0] !== 1'b0) begin nerr++; $display("FAIL clear_rty_pulse: got %b expected %b", rty[0], 1'b0); end
  endtask

  task automatic test_clear_zero();
    repeat (250) @(negedge clk);
    bus_access(0, 1'b0, 64'h7F8, 64'h0, 8'hFF, 16'h0001, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b100 || rd !== 64'h0) begin nerr++; $display("FAIL clear_zero_top: got resp=%b dat=%h expected resp=100 dat=0", resp, rd); end
    bus_access(3, 1'b0, 64'h100, 64'h0, 8'hFF, 16'h0002, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b100 || rd !== 64'h0 || lat !== 1) begin nerr++; $display("FAIL clear_zero_ws0: got resp=%b dat=%h lat=%0d expected 100/0/1", resp, rd, lat); end
  endtask

  task automatic test_write_read();
    bus_access(0, 1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, 8'hFF, 16'h00A5, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b100) begin nerr++; $display("FAIL wr_resp: got %b expected %b", resp, 3'b100); end
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL wr_lat: got %0d expected %0d", lat, 3); end
    nvec++; if (tg !== 16'h00A5) begin nerr++; $display("FAIL wr_tag: got %h expected %h", tg, 16'h00A5); end
    bus_access(0, 1'b0, 64'h10, 64'h0, 8'hFF, 16'h005A, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b100 || lat !== 3) begin nerr++; $display("FAIL rd_resp: got resp=%b lat=%0d expected 100/3", resp, lat); end
    nvec++; if (rd !== 64'hDEAD_BEEF_0123_4567) begin nerr++; $display("FAIL rd_data: got %h expected %h", rd, 64'hDEAD_BEEF_0123_4567); end
    nvec++; if (tg !== 16'h005A) begin nerr++; $display("FAIL rd_tag: got %h expected %h", tg, 16'h005A); end
  endtask

  task automatic test_byte_lanes();
    bus_access(0, 1'b1, 64'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 16'h0011, resp, rd, tg, lat);
    bus_access(0, 1'b1, 64'h18, 64'h0, 8'h0F, 16'h0012, resp, rd, tg, lat);
    bus_access(0, 1'b0, 64'h18, 64'h0, 8'hFF, 16'h0013, resp, rd, tg, lat);
    nvec++; if (rd !== 64'hFFFF_FFFF_0000_0000) begin nerr++; $display("FAIL lanes_lo: got %h expected %h", rd, 64'hFFFF_FFFF_0000_0000); end
    bus_access(0, 1'b1, 64'h18, 64'h1234_5678_9ABC_DEF0, 8'h00, 16'h0014, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b100) begin nerr++; $display("FAIL lanes_sel0_ack: got %b expected %b", resp, 3'b100); end
    bus_access(0, 1'b0, 64'h18, 64'h0, 8'hFF, 16'h0015, resp, rd, tg, lat);
    nvec++; if (rd !== 64'hFFFF_FFFF_0000_0000) begin nerr++; $display("FAIL lanes_sel0_data: got %h expected %h", rd, 64'hFFFF_FFFF_0000_0000); end
  endtask

  task automatic test_out_of_range();
    bus_access(1, 1'b1, 64'h1000, 64'h0123_4567_89AB_CDEF, 8'hFF, 16'h0100, resp, rd, tg, lat);
    bus_access(1, 1'b1, 64'h17F8, 64'hA5A5_0000_5A5A_FFFF, 8'hFF, 16'h0101, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b100 || lat !== 2) begin nerr++; $display("FAIL oor_top_wr: got resp=%b lat=%0d expected 100/2", resp, lat); end
    bus_access(1, 1'b0, 64'h0FF8, 64'h0, 8'hFF, 16'h0102, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b010 || rd !== 64'h0 || tg !== 16'h0102) begin nerr++; $display("FAIL oor_below: got resp=%b dat=%h tgd=%h expected 010/0/0102", resp, rd, tg); end
    bus_access(1, 1'b1, 64'h1800, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 16'h0103, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b010) begin nerr++; $display("FAIL oor_above: got %b expected %b", resp, 3'b010); end
    bus_access(1, 1'b0, 64'h1000, 64'h0, 8'hFF, 16'h0104, resp, rd, tg, lat);
    nvec++; if (rd !== 64'h0123_4567_89AB_CDEF) begin nerr++; $display("FAIL oor_nowrite: got %h expected %h", rd, 64'h0123_4567_89AB_CDEF); end
    bus_access(1, 1'b0, 64'h17FD, 64'h0, 8'hFF, 16'h0105, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b100 || rd !== 64'hA5A5_0000_5A5A_FFFF) begin nerr++; $display("FAIL oor_top_rd: got resp=%b dat=%h expected 100/%h", resp, rd, 64'hA5A5_0000_5A5A_FFFF); end
  endtask

  task automatic test_abort();
    logic seen;
    bus_access(2, 1'b1, 64'h40, 64'h1111_2222_3333_4444, 8'hFF, 16'h0200, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b100 || lat !== 5) begin nerr++; $display("FAIL abort_setup: got resp=%b lat=%0d expected 100/5", resp, lat); end
    @(negedge clk);
    we[2] = 1'b1; adr[2] = 64'h40; wdat[2] = 64'h9999_8888_7777_6666; sel[2] = 8'hFF; tga[2] = 16'h0201;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    repeat (2) @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ack[2] | err[2] | rty[2]) seen = 1'b1;
    end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL abort_noresp: got %b expected %b", seen, 1'b0); end
    bus_access(2, 1'b0, 64'h40, 64'h0, 8'hFF, 16'h0202, resp, rd, tg, lat);
    nvec++; if (rd !== 64'h1111_2222_3333_4444) begin nerr++; $display("FAIL abort_old: got %h expected %h", rd, 64'h1111_2222_3333_4444); end
    // CYC dropped while in RESP: the response and the write still happen.
    @(negedge clk);
    we[2] = 1'b1; adr[2] = 64'h40; wdat[2] = 64'h9999_8888_7777_6666; sel[2] = 8'hFF; tga[2] = 16'h0203;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    repeat (5) @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    @(negedge clk);
    nvec++; if (ack[2] !== 1'b1) begin nerr++; $display("FAIL late_drop_ack: got %b expected %b", ack[2], 1'b1); end
    bus_access(2, 1'b0, 64'h40, 64'h0, 8'hFF, 16'h0204, resp, rd, tg, lat);
    nvec++; if (rd !== 64'h9999_8888_7777_6666) begin nerr++; $display("FAIL late_drop_data: got %h expected %h", rd, 64'h9999_8888_7777_6666); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v [4];
    logic [15:0] t [4];
    int          n;
    v = '{64'h0A0A_0000_0000_0001, 64'h0B0B_0000_0000_0002, 64'h0C0C_0000_0000_0003, 64'h0D0D_0000_0000_0004};
    t = '{16'h3000, 16'h3001, 16'h3002, 16'h3003};
    for (int i = 0; i < 4; i++) begin
      bus_access(3, 1'b1, 64'(8 * i), v[i], 8'hFF, 16'h0, resp, rd, tg, lat);
    end
    @(negedge clk);
    we[3] = 1'b0; adr[3] = 64'h0; sel[3] = 8'hFF; tga[3] = t[0];
    cyc[3] = 1'b1; stb[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (ack[3]) begin n = k; break; end
      end
      nvec++; if (n !== 2) begin nerr++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, n, 2); end
      nvec++; if (dato[3] !== v[i]) begin nerr++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, dato[3], v[i]); end
      nvec++; if (tgdo[3] !== t[i]) begin nerr++; $display("FAIL b2b_tag[%0d]: got %h expected %h", i, tgdo[3], t[i]); end
      if (i < 3) begin
        adr[3] = 64'(8 * (i + 1)); tga[3] = t[i+1];
      end else begin
        cyc[3] = 1'b0; stb[3] = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    we[0] = 1'b0; adr[0] = 64'h10; sel[0] = 8'hFF; tga[0] = 16'h0101; cyc[0] = 1'b1; stb[0] = 1'b1;
    we[3] = 1'b0; adr[3] = 64'h8;  sel[3] = 8'hFF; tga[3] = 16'h0303; cyc[3] = 1'b1; stb[3] = 1'b1;
    repeat (2) @(negedge clk);
    nvec++; if (ack[3] !== 1'b1) begin nerr++; $display("FAIL rstmid_pre_ack: got %b expected %b", ack[3], 1'b1); end
    rst = 1'b0;
    #1;
    nvec++; if ({ack[3], err[3], rty[3]} !== 3'b000 || dato[3] !== 64'h0 || tgdo[3] !== 16'h0) begin nerr++; $display("FAIL rstmid_out3: got resp=%b dat=%h tgd=%h expected zero", {ack[3], err[3], rty[3]}, dato[3], tgdo[3]); end
    nvec++; if ({ack[0], err[0], rty[0]} !== 3'b000 || dato[0] !== 64'h0 || tgdo[0] !== 16'h0) begin nerr++; $display("FAIL rstmid_out0: got resp=%b dat=%h tgd=%h expected zero", {ack[0], err[0], rty[0]}, dato[0], tgdo[0]); end
    cyc = '0; stb = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    bus_access(0, 1'b0, 64'h10, 64'h0, 8'hFF, 16'h0777, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b001 || tg !== 16'h0777) begin nerr++; $display("FAIL rstmid_clear_rty: got resp=%b tgd=%h expected 001/0777", resp, tg); end
    repeat (260) @(negedge clk);
    bus_access(0, 1'b0, 64'h10, 64'h0, 8'hFF, 16'h0778, resp, rd, tg, lat);
    nvec++; if (resp !== 3'b100 || rd !== 64'h0) begin nerr++; $display("FAIL rstmid_rezero: got resp=%b dat=%h expected 100/0", resp, rd); end
  endtask

  initial begin
    rst = 1'b0;
    cyc = '0; stb = '0; we = '0;
    for (int d = 0; d < 4; d++) begin
      adr[d] = '0; wdat[d] = '0; sel[d] = '0; tga[d] = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_clear_retry();
    test_clear_zero();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
